led_blink_out: RTL



---
 rtl/led_blink_out_pkg.sv | 17 +
 rtl/led_blink_out_if.sv | 23 ++
 rtl/led_blink_out_tick_gen.sv | 30 +++
 rtl/led_blink_out.sv | 111 +++++++++++
 4 files changed

// File: rtl/led_blink_out_pkg.sv
// rtl/led_blink_out_pkg.sv - shared board-io constants and types for the LED blink stage
package led_blink_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Prescaler terminal count shared with the debounce block.
  localparam logic [19:0] TICK_10MS = 20'd1000000;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
    return (v >= max) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/led_blink_out_if.sv
// rtl/led_blink_out_if.sv - event in / LED status out bundle
interface led_blink_out_if;

  logic       evt_in;
  logic       led_out;
  logic       busy;
  logic [3:0] pending;

  modport master (
    output evt_in,
    input  led_out,
    input  busy,
    input  pending
  );

  modport slave (
    input  evt_in,
    output led_out,
    output busy,
    output pending
  );

endinterface

// File: rtl/led_blink_out_tick_gen.sv
// rtl/led_blink_out_tick_gen.sv - prescaler with synchronous clear and terminal-count tick
module tick_gen #(
  parameter logic [19:0] TICK_MAX = 20'd1000000
) (
  input  logic clock,
  input  logic n_reset,
  input  logic clr,
  output logic tick
);

  logic [19:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TICK_MAX);

  always_comb begin
    cnt_d = cnt_q + 20'd1;
    if (clr || tick) begin
      cnt_d = 20'd0;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= 20'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_out.sv
// rtl/led_blink_out.sv - turns event strobes into queued ON/OFF LED blinks
module led_blink_out
  import led_blink_out_pkg::*;
#(
  parameter logic [19:0] TICK_MAX  = TICK_10MS,
  parameter logic [7:0]  ON_TICKS  = 8'd25,
  parameter logic [7:0]  OFF_TICKS = 8'd25,
  parameter logic [3:0]  PEND_MAX  = 4'd15
) (
  input  logic           clock,
  input  logic           n_reset,
  led_blink_out_if.slave io
);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] pend_q, pend_d;
  logic       led_q, led_d;
  logic       busy_q, busy_d;
  logic       tick, clr, start, want, take_queued, evt_direct, evt_keep;
  logic [8:0] timer_inc;

  tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
    .clock  (clock),
    .n_reset(n_reset),
    .clr    (clr),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    start     = 1'b0;
    want      = io.evt_in || (pend_q != 4'd0);
    timer_inc = {1'b0, timer_q} + 9'd1;

    case (state_q)
      ST_IDLE: begin
        clr = 1'b1;
        if (want) begin
          start   = 1'b1;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (tick && timer_inc == {1'b0, ON_TICKS}) begin
          clr     = 1'b1;
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (tick && timer_inc == {1'b0, OFF_TICKS}) begin
          clr = 1'b1;
          if (want) begin
            start   = 1'b1;
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    timer_d = timer_q;
    if (clr) begin
      timer_d = 8'd0;
    end else if (tick) begin
      timer_d = timer_inc[7:0];
    end

    // A start drains the queue first; a fresh event only bypasses it when empty.
    take_queued = start && (pend_q != 4'd0);
    evt_direct  = start && (pend_q == 4'd0);
    evt_keep    = io.evt_in && !evt_direct;

    pend_d = pend_q;
    if (evt_keep && !take_queued) begin
      pend_d = sat_inc(pend_q, PEND_MAX);
    end else if (!evt_keep && take_queued) begin
      pend_d = pend_q - 4'd1;
    end

    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      timer_q <= 8'd0;
      pend_q  <= 4'd0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign io.led_out = led_q;
  assign io.busy    = busy_q;
  assign io.pending = pend_q;

endmodule
